// File: rtl/collision_pkg.sv
// collision_pkg: shared definitions for the collision/score stage.
//   - FSM state encoding (legacy localparam constants plus a typed enum)
//   - default parameter values for lives and invulnerability length
//   - bcd_inc_sat: four-digit BCD increment that sticks at 9999
package collision_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PLAY   = 2'd1;
  localparam logic [1:0] S_INVULN = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    PLAY   = S_PLAY,
    INVULN = S_INVULN,
    OVER   = S_OVER
  } state_t;

  localparam int DEF_START_LIVES   = 3;
  localparam int DEF_INVULN_FRAMES = 60;

  function automatic logic [15:0] bcd_inc_sat(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    if (v == 16'h9999) return v;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/collision_score_box_overlap.sv
// box_overlap: combinational axis-aligned box overlap test.
//   a_x, a_y, a_s : centre and half-size of box A (10 bits each)
//   b_x, b_y, b_s : centre and half-size of box B (10 bits each)
//   overlap       : 1 when |dx| < a_s+b_s and |dy| < a_s+b_s (touching edges excluded)
module box_overlap
  import collision_pkg::*;
(
  input  logic [9:0] a_x,
  input  logic [9:0] a_y,
  input  logic [9:0] a_s,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] b_s,
  output logic       overlap
);

  logic [10:0] dx, dy, lim;

  // 11-bit arithmetic so the absolute difference and the size sum never wrap
  always_comb begin
    dx      = (a_x >= b_x) ? ({1'b0, a_x} - {1'b0, b_x}) : ({1'b0, b_x} - {1'b0, a_x});
    dy      = (a_y >= b_y) ? ({1'b0, a_y} - {1'b0, b_y}) : ({1'b0, b_y} - {1'b0, a_y});
    lim     = {1'b0, a_s} + {1'b0, b_s};
    overlap = (dx < lim) && (dy < lim);
  end

endmodule

// File: rtl/collision_score.sv
// collision_score: per-frame bullet/ship vs meteor collision, BCD score,
// lives and game-over flow.
//   frame_clk, Reset            : frame clock, async active-high reset
//   start_screen                : title screen shown (forces/holds IDLE)
//   bullet_active/X/Y/size      : live bullet box
//   ship_X/Y/size               : ship box
//   met_active/X/Y/size         : packed meteor slots, slot i at [10i+9:10i]
//   bullet_hit, met_hit         : registered one-frame hit pulses
//   score_bcd, lives, game_over : registered game status
//
// state  | meaning
// IDLE   | title screen; score cleared, lives loaded, no pulses
// PLAY   | bullet and ship checks active
// INVULN | after a lost life; ship checks off for INVULN_FRAMES frames
// OVER   | no checks, score/lives frozen, game_over high
module collision_score
  import collision_pkg::*;
#(
  parameter int NUM_MET       = 4,
  parameter int START_LIVES   = DEF_START_LIVES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic                  start_screen,
  input  logic                  bullet_active,
  input  logic [9:0]            bullet_X,
  input  logic [9:0]            bullet_Y,
  input  logic [9:0]            bullet_size,
  input  logic [9:0]            ship_X,
  input  logic [9:0]            ship_Y,
  input  logic [9:0]            ship_size,
  input  logic [NUM_MET-1:0]    met_active,
  input  logic [NUM_MET*10-1:0] met_X,
  input  logic [NUM_MET*10-1:0] met_Y,
  input  logic [NUM_MET*10-1:0] met_size,
  output logic                  bullet_hit,
  output logic [NUM_MET-1:0]    met_hit,
  output logic [15:0]           score_bcd,
  output logic [1:0]            lives,
  output logic                  game_over
);

  localparam int               CW         = (INVULN_FRAMES > 2) ? $clog2(INVULN_FRAMES) : 1;
  localparam logic [CW-1:0]    INV_LOAD   = CW'(INVULN_FRAMES - 1);
  localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);
  localparam logic [NUM_MET-1:0] ONE      = NUM_MET'(1);

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [15:0]        score_n;
  logic [1:0]         lives_n;
  logic               bh_n, go_n;
  logic [NUM_MET-1:0] mh_n;

  logic [NUM_MET-1:0] bul_ov, ship_ov, bul_cand, ship_cand, bul_one, ship_one;
  logic               bul_fire, ship_fire;

  for (genvar i = 0; i < NUM_MET; i++) begin : g_ov
    box_overlap u_bul (
      .a_x(bullet_X), .a_y(bullet_Y), .a_s(bullet_size),
      .b_x(met_X[10*i +: 10]), .b_y(met_Y[10*i +: 10]), .b_s(met_size[10*i +: 10]),
      .overlap(bul_ov[i])
    );
    box_overlap u_ship (
      .a_x(ship_X), .a_y(ship_Y), .a_s(ship_size),
      .b_x(met_X[10*i +: 10]), .b_y(met_Y[10*i +: 10]), .b_s(met_size[10*i +: 10]),
      .overlap(ship_ov[i])
    );
  end

  // x & -x isolates the lowest set bit: lowest-index candidate wins
  always_comb begin
    bul_cand  = met_active & bul_ov;
    ship_cand = met_active & ship_ov;
    bul_one   = bul_cand & (~bul_cand + ONE);
    ship_one  = ship_cand & (~ship_cand + ONE);
    // gating on the registered pulse keeps a retiring bullet from scoring twice
    bul_fire  = bullet_active && !bullet_hit && ((state == PLAY) || (state == INVULN))
                && (|bul_cand);
    ship_fire = (state == PLAY) && (|ship_cand);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    score_n = score_bcd;
    lives_n = lives;
    bh_n    = 1'b0;
    mh_n    = '0;
    case (state)
      IDLE: begin
        score_n = 16'h0000;
        lives_n = LIVES_INIT;
        cnt_n   = '0;
        if (!start_screen) state_n = PLAY;
      end
      PLAY, INVULN: begin
        if (start_screen) begin
          state_n = IDLE;
          score_n = 16'h0000;
          lives_n = LIVES_INIT;
          cnt_n   = '0;
        end else begin
          bh_n = bul_fire;
          mh_n = (bul_fire ? bul_one : '0) | (ship_fire ? ship_one : '0);
          if (bul_fire) score_n = bcd_inc_sat(score_bcd);
          if (state == INVULN) begin
            if (cnt == '0) state_n = PLAY;
            else           cnt_n   = cnt - CW'(1);
          end
          if (ship_fire) begin
            lives_n = lives - 2'd1;
            if (lives == 2'd1) begin
              state_n = OVER;
            end else begin
              state_n = INVULN;
              cnt_n   = INV_LOAD;
            end
          end
        end
      end
      OVER: begin
        if (start_screen) begin
          state_n = IDLE;
          score_n = 16'h0000;
          lives_n = LIVES_INIT;
        end
      end
      default: state_n = IDLE;
    endcase
    go_n = (state_n == OVER);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bullet_hit <= 1'b0;
      met_hit    <= '0;
      score_bcd  <= 16'h0000;
      lives      <= LIVES_INIT;
      game_over  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bullet_hit <= bh_n;
      met_hit    <= mh_n;
      score_bcd  <= score_n;
      lives      <= lives_n;
      game_over  <= go_n;
    end
  end

endmodule

// File: tb/tb_collision_score.sv
// tb_collision_score: table vectors, hand sequences for multi-frame corners,
// and randomized frames checked against a behavioural game model.
module tb_collision_score;

  localparam int INV = 60;
  localparam int M_IDLE = 0, M_PLAY = 1, M_INV = 2, M_OVER = 3;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic        start_screen, bullet_active;
  logic [9:0]  bullet_X, bullet_Y, bullet_size, ship_X, ship_Y, ship_size;
  logic [3:0]  met_active;
  logic [39:0] met_X, met_Y, met_size;
  logic        bullet_hit, game_over;
  logic [3:0]  met_hit;
  logic [15:0] score_bcd;
  logic [1:0]  lives;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  int       m_mode, m_score, m_lives, m_inv;
  logic     m_bhit;
  logic [3:0] m_mhit;

  collision_score #(.NUM_MET(4), .START_LIVES(3), .INVULN_FRAMES(INV)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .start_screen(start_screen),
    .bullet_active(bullet_active), .bullet_X(bullet_X), .bullet_Y(bullet_Y),
    .bullet_size(bullet_size), .ship_X(ship_X), .ship_Y(ship_Y), .ship_size(ship_size),
    .met_active(met_active), .met_X(met_X), .met_Y(met_Y), .met_size(met_size),
    .bullet_hit(bullet_hit), .met_hit(met_hit), .score_bcd(score_bcd),
    .lives(lives), .game_over(game_over)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    logic        b_act;
    logic [9:0]  bx, by, bs;
    logic [3:0]  mact;
    logic [39:0] mx, my, ms;
    logic        exp_b;
    logic [3:0]  exp_m;
  } vec_t;
  vec_t vt[11];

  function automatic logic [39:0] p4(input int s0, input int s1, input int s2, input int s3);
    return {10'(s3), 10'(s2), 10'(s1), 10'(s0)};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit ov(input int ax, input int ay, input int as,
                            input int bx, input int by, input int bs);
    int dx, dy;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    return (dx < as + bs) && (dy < as + bs);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_score = 0; m_lives = 3; m_inv = 0; m_bhit = 1'b0; m_mhit = 4'b0;
  endtask

  task automatic model_step();
    int bsel, ssel;
    bsel = -1; ssel = -1;
    if ((m_mode == M_PLAY || m_mode == M_INV) && !start_screen) begin
      if (bullet_active && !m_bhit)
        for (int i = 0; i < 4; i++)
          if (bsel < 0 && met_active[i] &&
              ov(bullet_X, bullet_Y, bullet_size, met_X[10*i +: 10], met_Y[10*i +: 10], met_size[10*i +: 10]))
            bsel = i;
      if (m_mode == M_PLAY)
        for (int i = 0; i < 4; i++)
          if (ssel < 0 && met_active[i] &&
              ov(ship_X, ship_Y, ship_size, met_X[10*i +: 10], met_Y[10*i +: 10], met_size[10*i +: 10]))
            ssel = i;
    end
    m_bhit = (bsel >= 0);
    m_mhit = 4'b0;
    if (bsel >= 0) m_mhit[bsel] = 1'b1;
    if (ssel >= 0) m_mhit[ssel] = 1'b1;
    case (m_mode)
      M_IDLE: if (!start_screen) m_mode = M_PLAY;
      M_PLAY, M_INV: begin
        if (start_screen) begin
          m_mode = M_IDLE; m_score = 0; m_lives = 3;
        end else begin
          if (bsel >= 0 && m_score < 9999) m_score++;
          if (m_mode == M_INV) begin
            m_inv--;
            if (m_inv == 0) m_mode = M_PLAY;
          end
          if (ssel >= 0) begin
            m_lives--;
            if (m_lives == 0) m_mode = M_OVER;
            else begin m_mode = M_INV; m_inv = INV; end
          end
        end
      end
      default: if (start_screen) begin m_mode = M_IDLE; m_score = 0; m_lives = 3; end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge frame_clk);
    #1;
    chk("bullet_hit", 32'(bullet_hit), 32'(m_bhit));
    chk("met_hit", 32'(met_hit), 32'(m_mhit));
    chk("score_bcd", 32'(score_bcd), 32'(to_bcd(m_score)));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("game_over", 32'(game_over), 32'(m_mode == M_OVER));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bullet_hit"}, 32'(bullet_hit), 32'd0);
    chk({tag, "_met_hit"}, 32'(met_hit), 32'd0);
    chk({tag, "_score"}, 32'(score_bcd), 32'h0000);
    chk({tag, "_lives"}, 32'(lives), 32'd3);
    chk({tag, "_game_over"}, 32'(game_over), 32'd0);
  endtask

  task automatic ship_far();
    ship_X = 10'd900; ship_Y = 10'd900; ship_size = 10'd1;
  endtask

  initial begin
    int tbl_score;
    logic       seq_b[3];
    logic [3:0] seq_m[3];

    vt[0]  = '{1'b1, 10'd100, 10'd200, 10'd3, 4'b0100, p4(500,500,104,500), p4(500,500,205,500), p4(1,1,8,1), 1'b1, 4'b0100};
    vt[1]  = '{1'b1, 10'd100, 10'd100, 10'd3, 4'b0001, p4(108,500,500,500), p4(100,500,500,500), p4(5,1,1,1), 1'b0, 4'b0000};
    vt[2]  = '{1'b1, 10'd100, 10'd100, 10'd3, 4'b0001, p4(107,500,500,500), p4(100,500,500,500), p4(5,1,1,1), 1'b1, 4'b0001};
    vt[3]  = '{1'b1, 10'd100, 10'd100, 10'd3, 4'b0001, p4(100,500,500,500), p4(120,500,500,500), p4(5,1,1,1), 1'b0, 4'b0000};
    vt[4]  = '{1'b1, 10'd100, 10'd100, 10'd3, 4'b0001, p4(100,500,500,500), p4(108,500,500,500), p4(5,1,1,1), 1'b0, 4'b0000};
    vt[5]  = '{1'b1, 10'd100, 10'd100, 10'd3, 4'b0001, p4(103,500,500,500), p4(107,500,500,500), p4(5,1,1,1), 1'b1, 4'b0001};
    vt[6]  = '{1'b1, 10'd300, 10'd300, 10'd4, 4'b1010, p4(500,302,500,299), p4(500,301,500,298), p4(1,3,1,6), 1'b1, 4'b0010};
    vt[7]  = '{1'b1, 10'd300, 10'd300, 10'd4, 4'b0000, p4(500,302,500,299), p4(500,301,500,298), p4(1,3,1,6), 1'b0, 4'b0000};
    vt[8]  = '{1'b0, 10'd300, 10'd300, 10'd4, 4'b1010, p4(500,302,500,299), p4(500,301,500,298), p4(1,3,1,6), 1'b0, 4'b0000};
    vt[9]  = '{1'b1, 10'd0,   10'd0,   10'd2, 4'b0001, p4(1020,500,500,500), p4(0,500,500,500), p4(5,1,1,1), 1'b0, 4'b0000};
    vt[10] = '{1'b1, 10'd50,  10'd50,  10'd4, 4'b1000, p4(500,500,500,45), p4(500,500,500,47), p4(1,1,1,2), 1'b1, 4'b1000};

    // reset and enter PLAY
    Reset = 1'b1; start_screen = 1'b1; bullet_active = 1'b0;
    bullet_X = '0; bullet_Y = '0; bullet_size = '0; ship_far();
    met_active = '0; met_X = '0; met_Y = '0; met_size = '0;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    chk_reset_vals("por");
    Reset = 1'b0;
    tick();
    start_screen = 1'b0;
    tick();

    // table vectors, each followed by a frame with the bullet retired
    tbl_score = 0;
    for (int v = 0; v < 11; v++) begin
      bullet_active = vt[v].b_act; bullet_X = vt[v].bx; bullet_Y = vt[v].by; bullet_size = vt[v].bs;
      met_active = vt[v].mact; met_X = vt[v].mx; met_Y = vt[v].my; met_size = vt[v].ms;
      tick();
      tbl_score += int'(vt[v].exp_b);
      chk($sformatf("vec%0d_bullet_hit", v), 32'(bullet_hit), 32'(vt[v].exp_b));
      chk($sformatf("vec%0d_met_hit", v), 32'(met_hit), 32'(vt[v].exp_m));
      chk($sformatf("vec%0d_score", v), 32'(score_bcd), 32'(to_bcd(tbl_score)));
      bullet_active = 1'b0;
      tick();
    end

    // bullet held over slots 1 and 3 for three frames: pulses 1,0,1
    seq_b[0] = 1'b1; seq_b[1] = 1'b0; seq_b[2] = 1'b1;
    seq_m[0] = 4'b0010; seq_m[1] = 4'b0000; seq_m[2] = 4'b0010;
    bullet_active = 1'b1; bullet_X = 10'd300; bullet_Y = 10'd300; bullet_size = 10'd4;
    met_active = 4'b1010; met_X = p4(500,302,500,299); met_Y = p4(500,301,500,298); met_size = p4(1,3,1,6);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold%0d_bullet_hit", k), 32'(bullet_hit), 32'(seq_b[k]));
      chk($sformatf("hold%0d_met_hit", k), 32'(met_hit), 32'(seq_m[k]));
    end
    chk("hold_score", 32'(score_bcd), 32'(to_bcd(tbl_score + 2)));
    bullet_active = 1'b0;
    tick();

    // ship parked on slot 0: lose lives with INVULN gaps until OVER
    met_active = 4'b0001; met_X = p4(400,500,500,500); met_Y = p4(400,500,500,500); met_size = p4(5,1,1,1);
    ship_X = 10'd402; ship_Y = 10'd403; ship_size = 10'd4;
    tick();
    chk("ship1_lives", 32'(lives), 32'd2);
    chk("ship1_met_hit", 32'(met_hit), 32'b0001);
    for (int k = 0; k < INV; k++) begin
      tick();
      chk("invuln_lives", 32'(lives), 32'd2);
      chk("invuln_met_hit", 32'(met_hit), 32'd0);
    end
    tick();
    chk("ship2_lives", 32'(lives), 32'd1);
    for (int k = 0; k < INV; k++) tick();
    tick();
    chk("ship3_lives", 32'(lives), 32'd0);
    chk("ship3_game_over", 32'(game_over), 32'd1);
    chk("ship3_met_hit", 32'(met_hit), 32'b0001);
    tick();
    chk("over_frozen_lives", 32'(lives), 32'd0);
    chk("over_no_pulse", 32'(met_hit), 32'd0);

    // OVER -> IDLE -> PLAY
    start_screen = 1'b1;
    tick();
    chk("idle_score", 32'(score_bcd), 32'h0000);
    chk("idle_lives", 32'(lives), 32'd3);
    chk("idle_game_over", 32'(game_over), 32'd0);
    start_screen = 1'b0;
    tick();
    chk("enter_play_lives", 32'(lives), 32'd3);
    tick();
    chk("play_ship_hit_lives", 32'(lives), 32'd2);
    ship_far(); met_active = 4'b0000;

    // score to 0042 while entering INVULN, then async reset mid-frame
    bullet_active = 1'b1; bullet_X = 10'd100; bullet_Y = 10'd200; bullet_size = 10'd3;
    met_active = 4'b0100; met_X = p4(400,500,104,500); met_Y = p4(400,500,205,500); met_size = p4(5,1,8,1);
    for (int k = 0; k < 200 && m_score < 41; k++) tick();
    bullet_active = 1'b0;
    tick();
    bullet_active = 1'b1; met_active = 4'b0101;
    ship_X = 10'd402; ship_Y = 10'd403; ship_size = 10'd4;
    tick();
    chk("dual_met_hit", 32'(met_hit), 32'b0101);
    chk("dual_bullet_hit", 32'(bullet_hit), 32'd1);
    chk("dual_score", 32'(score_bcd), 32'h0042);
    chk("dual_lives", 32'(lives), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk_reset_vals("async");
    model_reset();
    @(posedge frame_clk);
    #1;
    chk_reset_vals("held");
    Reset = 1'b0;
    ship_far(); bullet_active = 1'b0; met_active = 4'b0000;
    tick();

    // saturate the score at 9999
    bullet_active = 1'b1; met_active = 4'b0100;
    for (int k = 0; k < 25000 && m_score < 9999; k++) tick();
    for (int k = 0; k < 4; k++) tick();
    chk("saturated_score", 32'(score_bcd), 32'h9999);

    // randomized frames against the model
    for (int k = 0; k < 3000; k++) begin
      start_screen  = ($urandom_range(0, 49) == 0);
      bullet_active = ($urandom_range(0, 3) != 0);
      bullet_X = 10'($urandom_range(0, 80)); bullet_Y = 10'($urandom_range(0, 80));
      bullet_size = 10'($urandom_range(0, 12));
      ship_X = 10'($urandom_range(0, 80)); ship_Y = 10'($urandom_range(0, 80));
      ship_size = 10'($urandom_range(0, 8));
      met_active = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        met_X[10*i +: 10] = 10'($urandom_range(0, 80));
        met_Y[10*i +: 10] = 10'($urandom_range(0, 80));
        met_size[10*i +: 10] = 10'($urandom_range(0, 12));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
